// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter: opcode encoding, output FSM
// states and the default datapath width.
package logic_unit_pkg;

  localparam int LU_WIDTH = 32;

  typedef enum logic [1:0] {
    LU_AND = 2'b00,
    LU_OR  = 2'b01,
    LU_XOR = 2'b10,
    LU_NOR = 2'b11
  } lu_op_e;

  // Output register occupancy; FULL is exactly rsp_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit: one operand pair in, one result out.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (lu_op_e'(op))
      LU_AND:  result = a & b;
      LU_OR:   result = a | b;
      LU_XOR:  result = a ^ b;
      LU_NOR:  result = ~(a | b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit among NUM_REQ requesters with a
// single registered result. Define LOGIC_ARB_FIXED_PRI_EN for fixed priority.
//
// Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i];
// a result transfers where rsp_valid && rsp_ready. Requesters hold their
// payload stable until ready; rsp_* is held stable while rsp_ready is low.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = LU_WIDTH,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_result
);

  out_state_e         state_q, state_d;
  logic               run_q;
  logic               can_accept;
  logic               grant_found;
  int                 grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               xfer;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [WIDTH-1:0]   lu_result;

  // run_q keeps every req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

`ifdef LOGIC_ARB_FIXED_PRI_EN
  // Lowest asserted index wins; scanning downward leaves the lowest one last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = i;
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q;

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = 0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Priority rotates only on a transfer, never on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer) begin
      if (grant_idx == NUM_REQ - 1) ptr_q <= '0;
      else                          ptr_q <= IDW'(grant_idx + 1);
    end
  end
`endif

  always_comb begin
    grant_oh = '0;
    grant_oh[grant_idx] = grant_found;
  end

  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
  assign req_ready  = (run_q && can_accept) ? grant_oh : '0;
  assign xfer       = |(req_valid & req_ready);

  assign sel_op = req_op[2*grant_idx +: 2];
  assign sel_a  = req_a[WIDTH*grant_idx +: WIDTH];
  assign sel_b  = req_b[WIDTH*grant_idx +: WIDTH];

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (lu_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL: begin
        if (xfer)           state_d = ST_FULL;
        else if (rsp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Result and id keep their last value after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_id     <= '0;
    end else if (xfer) begin
      rsp_result <= lu_result;
      rsp_id     <= IDW'(grant_idx);
    end
  end

  assign rsp_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (NUM_REQ=2, WIDTH=32).
module tb_logic_unit_arbiter;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 32;
  localparam int IDW     = 1;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;

  int n_checks = 0;
  int n_fail   = 0;

  logic_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[2*i +: 2]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    n_checks++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", rsp_result); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL release_ready got=%b exp=00", req_ready); end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_single_xor();
    @(negedge clk);
    set_req(0, 2'b10, 32'hFFFF0000, 32'h0F0F0F0F);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL xor_ready got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL xor_valid got=%b exp=1", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL xor_id got=%0d exp=0", rsp_id); end
    n_checks++; if (rsp_result !== 32'hF0F00F0F) begin n_fail++; $display("FAIL xor_result got=%h exp=F0F00F0F", rsp_result); end
  endtask

  task automatic test_nor_and_drain();
    @(negedge clk);
    set_req(1, 2'b11, 32'h0, 32'h0);
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL nor_ready got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b00;
    n_checks++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL nor_id got=%0d exp=1", rsp_id); end
    n_checks++; if (rsp_result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL nor_result got=%h exp=FFFFFFFF", rsp_result); end
    step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL drain_keep got=%h exp=FFFFFFFF", rsp_result); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic        exp_id;
    logic [31:0] exp_res;
    @(negedge clk);
    set_req(0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
    set_req(1, 2'b01, 32'h0000FFFF, 32'h00FF0000);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef LOGIC_ARB_FIXED_PRI_EN
      exp_id = 1'b0;
`else
      exp_id = (i % 2 == 1);
`endif
      exp_rdy = exp_id ? 2'b10 : 2'b01;
      exp_res = exp_id ? 32'h00FFFFFF : 32'hF000F000;
      #1;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy); end
      step();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, rsp_valid); end
      n_checks++; if (rsp_id !== exp_id) begin n_fail++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", i, rsp_id, exp_id); end
      n_checks++; if (rsp_result !== exp_res) begin n_fail++; $display("FAIL rr_result[%0d] got=%h exp=%h", i, rsp_result, exp_res); end
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(0, 2'b10, 32'h12345678, 32'hFFFFFFFF);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    step();
    set_req(1, 2'b00, 32'hFFFFFFFF, 32'hA5A5A5A5);
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, req_ready); end
      step();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_id[%0d] got=%0d exp=0", i, rsp_id); end
      n_checks++; if (rsp_result !== 32'hEDCBA987) begin n_fail++; $display("FAIL bp_result[%0d] got=%h exp=EDCBA987", i, rsp_result); end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b00;
    n_checks++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_next_id got=%0d exp=1", rsp_id); end
    n_checks++; if (rsp_result !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bp_next_result got=%h exp=A5A5A5A5", rsp_result); end
    step();
  endtask

  task automatic test_idle_no_rotate();
    logic [1:0] exp_rdy;
    // Grant req 1, idle, then both valid: req 0 wins.
    set_req(0, 2'b01, 32'h00000011, 32'h00000100);
    set_req(1, 2'b01, 32'h00002200, 32'h00000022);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    repeat (3) step();
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL idle1_ready got=%b exp=01", req_ready); end
    // Grant req 0, idle, then both valid: round robin favours req 1.
    req_valid = 2'b01;
    step();
    n_checks++; if (rsp_result !== 32'h00000111) begin n_fail++; $display("FAIL idle_result got=%h exp=00000111", rsp_result); end
    req_valid = 2'b00;
    repeat (3) step();
    req_valid = 2'b11;
`ifdef LOGIC_ARB_FIXED_PRI_EN
    exp_rdy = 2'b01;
`else
    exp_rdy = 2'b10;
`endif
    #1;
    n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL idle2_ready got=%b exp=%b", req_ready, exp_rdy); end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_mid_reset();
    set_req(0, 2'b00, 32'hFFFFFFFF, 32'h0000BEEF);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    step();
    req_valid = 2'b11;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mr_full got=%b exp=1", rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_async_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL mr_result got=%h exp=0", rsp_result); end
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mr_hold_ready got=%b exp=00", req_ready); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mr_release_ready got=%b exp=00", req_ready); end
    step();
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mr_first_ready got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL mr_first_id got=%0d exp=0", rsp_id); end
    n_checks++; if (rsp_result !== 32'h0000BEEF) begin n_fail++; $display("FAIL mr_first_result got=%h exp=0000BEEF", rsp_result); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_xor();
    test_nor_and_drain();
    test_round_robin();
    test_backpressure();
    test_idle_no_rotate();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter sharing one 32-bit bitwise logic unit (AND/OR/XOR/NOR) among NUM_REQ requesters via valid/ready handshakes. It sits beside the ALU and serves auxiliary clients such as the checksum/parity helpers and the debug port. A single output register holds the result and returns it tagged with the requester index.

## Interface
- NUM_REQ, 2, number of requesters; legal range 1..8
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_op  in  2*NUM_REQ  opcode, requester i at [2i+1:2i]
- req_a  in  WIDTH*NUM_REQ  operand A, requester i at [WIDTH*i +: WIDTH]
- req_b  in  WIDTH*NUM_REQ  operand B, same packing
- rsp_valid  out  1  result register full
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester owning the result; IDW = max(1, $clog2(NUM_REQ))
- rsp_result  out  WIDTH  registered result

## Operation
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 NOR (bitwise, full WIDTH, no flags).
- Output FSM, two states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = EMPTY, or FULL with rsp_ready=1.
- Grant: one requester per cycle by round robin; search starts at index ptr, wrapping past NUM_REQ-1 to 0.
- req_ready[g] = can_accept && req_valid[g] for granted g; all other bits 0. Combinational from req_valid, rsp_ready, state.
- On transfer (req_valid[g] && req_ready[g]): rsp_result <= op(a,b) of g, rsp_id <= g, state -> FULL, ptr <= g+1 mod NUM_REQ.
- FULL with rsp_ready=1 and no transfer: state -> EMPTY; rsp_result/rsp_id keep their last value.
- FULL with rsp_ready=0: rsp_* held stable, all req_ready=0, ptr unchanged.
- ptr advances only on a transfer; idle cycles do not rotate priority.
- Requesters hold valid, op and operands stable until ready; a dropped valid before grant is legal and simply loses arbitration.
- NUM_REQ=1: grant always 0; rsp_id constant 0.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, ptr=0, state EMPTY; req_ready=0 while reset is asserted.
- Latency: request accepted in cycle N, rsp_valid=1 with result in cycle N+1.
- Throughput: one result per cycle when rsp_ready is held high (drain and accept in the same cycle, no bubble).
- Reset mid-operation: a held result is discarded, ptr returns to 0, and no req_ready is asserted until the first edge after deassertion.
- No combinational path from req_* to rsp_*; rsp_ready→req_ready is combinational.

## Configuration
- LOGIC_ARB_FIXED_PRI_EN defined: fixed priority, lowest asserted index always wins; ptr register removed.
- Undefined (default): round robin as described above.
- Handshake, latency and FSM are identical in both builds.

## Structure
- Shared package logic_unit_pkg holds a typedef enum of the 2-bit opcode (LU_AND, LU_OR, LU_XOR, LU_NOR) and the WIDTH default constant.
- Sub-module logic_unit: combinational op/a/b→result for one operand pair, instantiated once after the grant mux.
- Arbiter, mux, FSM and output register live in logic_unit_arbiter.

## Test plan
- Reset check: hold rst_n=0 with all req_valid=1 → req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0.
- Single XOR: req 0 sends op 10, a=FFFF0000, b=0F0F0F0F with rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=F0F00F0F; NOR of 0,0 → FFFFFFFF.
- Round robin: both requesters valid continuously, rsp_ready=1 → grants alternate 0,1,0,1 with one result per cycle. With LOGIC_ARB_FIXED_PRI_EN, grants are 0,0,0,0.
- Backpressure: rsp_ready=0 for 5 cycles while FULL → rsp_result/rsp_id stable, req_ready=0; raising rsp_ready accepts the next request in the same cycle.
- Idle no-rotate: req 1 granted, then 3 idle cycles, then both valid → req 0 wins.
- Mid-operation reset: assert rst_n=0 while FULL → rsp_valid drops asynchronously; after release, first grant goes to req 0.
